// File: rtl/sseg_multi_drv.sv
// N-digit seven-segment driver: double-buffered hex display with blank/blink/dp,
// leading-zero suppression and PWM brightness. Outputs are active-low per digit.
module sseg_multi_drv #(
  parameter int N_DIG     = 4,
  parameter int BLINK_DIV = 25000000,
  parameter int PWM_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIG-1:0]    data,
  input  logic [N_DIG-1:0]      dp,
  input  logic [N_DIG-1:0]      blank,
  input  logic [N_DIG-1:0]      blink,
  input  logic                  lzb_en,
  input  logic [PWM_BITS-1:0]   bright,
  output logic [8*N_DIG-1:0]    led,
  output logic                  frame
);

  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

  logic [PWM_BITS-1:0] cnt;
  logic                wrap;
  logic [BW-1:0]       presc;
  logic                phase;

  logic                pend;
  logic [4*N_DIG-1:0]  p_data, c_data;
  logic [N_DIG-1:0]    p_dp, c_dp;
  logic [N_DIG-1:0]    p_blank, c_blank;
  logic [N_DIG-1:0]    p_blink, c_blink;
  logic                p_lzb, c_lzb;

  logic [8*N_DIG-1:0]  led_nxt;

  assign wrap     = &cnt;
  assign in_ready = ~pend;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h27;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h58;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      frame <= 1'b0;
      presc <= '0;
      phase <= 1'b1;
    end else begin
      cnt   <= cnt + 1'b1;
      frame <= wrap;
      if (presc == BLINK_TC) begin
        presc <= '0;
        phase <= ~phase;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Pending is only promoted on a wrap, so a frame never shows a mix of old and new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      p_data  <= '0;
      p_dp    <= '0;
      p_blank <= '1;
      p_blink <= '0;
      p_lzb   <= 1'b0;
      c_data  <= '0;
      c_dp    <= '0;
      c_blank <= '1;
      c_blink <= '0;
      c_lzb   <= 1'b0;
    end else if (pend && wrap) begin
      pend    <= 1'b0;
      c_data  <= p_data;
      c_dp    <= p_dp;
      c_blank <= p_blank;
      c_blink <= p_blink;
      c_lzb   <= p_lzb;
    end else if (in_valid && !pend) begin
      pend    <= 1'b1;
      p_data  <= data;
      p_dp    <= dp;
      p_blank <= blank;
      p_blink <= blink;
      p_lzb   <= lzb_en;
    end
  end

  always_comb begin
    logic       gate_on;
    logic       supp;
    logic [7:0] seg;
    led_nxt = '1;
    gate_on = (&bright) | (cnt < bright);
    supp    = 1'b0;
    seg     = '0;
    for (int i = 0; i < N_DIG; i++) begin
      // Suppression looks only at data values, never at the blank mask.
      supp = c_lzb && (i > 0) && ((c_data >> (4 * i)) == '0);
      seg  = {c_dp[i], supp ? 7'h00 : glyph(c_data[4*i +: 4])};
      if (!c_blank[i] && (phase || !c_blink[i]) && gate_on)
        led_nxt[8*i +: 8] = ~seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= '1;
    else        led <= led_nxt;
  end

endmodule

// File: tb/tb_sseg_multi_drv.sv
// Bench for sseg_multi_drv: cycle-count based reference model compared every cycle,
// plus directed scenarios with hand-computed segment patterns.
module tb_sseg_multi_drv;

  localparam int N_DIG     = 4;
  localparam int BLINK_DIV = 4;
  localparam int PWM_BITS  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  blink = '0;
  logic        lzb_en = 1'b0;
  logic [3:0]  bright = 4'hF;
  logic [31:0] led;
  logic        frame;

  int n_cmp = 0;
  int n_bad = 0;

  sseg_multi_drv #(.N_DIG(N_DIG), .BLINK_DIV(BLINK_DIV), .PWM_BITS(PWM_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .dp(dp), .blank(blank), .blink(blink), .lzb_en(lzb_en),
    .bright(bright), .led(led), .frame(frame)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset determines PWM count and blink phase.
  logic [7:0]  glyph_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h27,
                                  8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h58, 8'h5E, 8'h79, 8'h71};
  int          mtime = 0;
  int          n_xfer = 0;
  logic        mpend = 1'b0;
  logic [15:0] c_data = '0, p_data = '0;
  logic [3:0]  c_dp = '0, c_blank = '1, c_blink = '0;
  logic [3:0]  p_dp = '0, p_blank = '1, p_blink = '0;
  logic        c_lzb = 1'b0, p_lzb = 1'b0;
  logic [31:0] exp_led = '1;
  logic        exp_frame = 1'b0;

  function automatic logic [31:0] model_led(input logic [15:0] d, input logic [3:0] p,
      input logic [3:0] bl, input logic [3:0] bk, input logic lz, input logic ph,
      input int cnt, input int br);
    logic [31:0] r;
    logic [7:0]  seg;
    int          top;
    r   = '1;
    top = -1;
    for (int i = 0; i < 4; i++) if (((d >> (4 * i)) & 16'hF) != 0) top = i;
    for (int i = 0; i < 4; i++) begin
      seg = (lz && i > 0 && i > top) ? 8'h00 : glyph_tab[(d >> (4 * i)) & 16'hF];
      if (p[i]) seg = seg | 8'h80;
      if (!bl[i] && (!bk[i] || ph) && (br == 15 || cnt < br))
        r[8*i +: 8] = ~seg;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int   mcnt;
    logic mph;
    if (!rst_n) begin
      mtime = 0; mpend = 1'b0;
      c_data = '0; c_dp = '0; c_blank = '1; c_blink = '0; c_lzb = 1'b0;
      exp_led = '1; exp_frame = 1'b0;
    end else begin
      mcnt = mtime % 16;
      mph  = ((mtime / BLINK_DIV) % 2) == 0;
      exp_led   = model_led(c_data, c_dp, c_blank, c_blink, c_lzb, mph, mcnt, int'(bright));
      exp_frame = (mcnt == 15);
      if (mpend && mcnt == 15) begin
        c_data = p_data; c_dp = p_dp; c_blank = p_blank; c_blink = p_blink; c_lzb = p_lzb;
        mpend = 1'b0;
      end else if (in_valid && !mpend) begin
        p_data = data; p_dp = dp; p_blank = blank; p_blink = blink; p_lzb = lzb_en;
        mpend = 1'b1;
        n_xfer++;
      end
      mtime++;
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if (led !== exp_led) begin
      n_bad++;
      $display("FAIL model_led t=%0t got=%h want=%h", $time, led, exp_led);
    end
    n_cmp++;
    if (in_ready !== !mpend) begin
      n_bad++;
      $display("FAIL model_in_ready t=%0t got=%b want=%b", $time, in_ready, !mpend);
    end
    n_cmp++;
    if (frame !== exp_frame) begin
      n_bad++;
      $display("FAIL model_frame t=%0t got=%b want=%b", $time, frame, exp_frame);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  task automatic xfer(input logic [15:0] d, input logic [3:0] p, input logic [3:0] bl,
                      input logic [3:0] bk, input logic lz);
    int start;
    bit ok;
    start = n_xfer;
    ok = 0;
    @(negedge clk); #1;
    data = d; dp = p; blank = bl; blink = bk; lzb_en = lz; in_valid = 1'b1;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (n_xfer != start) ok = 1;
    end
    #1 in_valid = 1'b0;
    check("xfer_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_applied();
    bit ok;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (!mpend) ok = 1;
    end
    check("apply_timeout", 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_cnt(input int v);
    bit ok;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (mtime % 16 == v) ok = 1;
    end
    check("cnt_timeout", 32'(ok), 32'd1);
  endtask

  task automatic count_window(input int len, input int dig, input logic [7:0] val, output int c);
    c = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (led[8*dig +: 8] == val) c++;
    end
  endtask

  initial begin
    int c;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led", led, 32'hFFFF_FFFF);
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_frame", 32'(frame), 32'd0);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_dark", led, 32'hFFFF_FFFF);

    xfer(16'hFE10, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    wait_applied();
    check("decode_FE10", led, 32'h8E86_F940);

    // handshake timing: accept at cnt=5, second request held across pending period
    wait_cnt(5);
    #1 data = 16'h5A3C; dp = '0; blank = '0; blink = '0; lzb_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("hs_ready_low", 32'(in_ready), 32'd0);
    #1 data = 16'hC0DE;
    wait_cnt(15);
    check("hs_pre_wrap_led", led, 32'h8E86_F940);
    check("hs_pre_wrap_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("hs_wrap_led_old", led, 32'h8E86_F940);
    check("hs_wrap_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("hs_new_led", led, 32'h9288_B0A7);
    check("hs_second_taken", 32'(in_ready), 32'd0);
    #1 in_valid = 1'b0;
    wait_applied();
    check("hs_second_led", led, 32'hA7C0_A186);

    xfer(16'h0030, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    wait_applied();
    check("lzb_0030", led, 32'hFF7F_B0C0);
    xfer(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    wait_applied();
    check("lzb_0000", led, 32'hFFFF_FFC0);

    xfer(16'h1111, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    wait_applied();
    count_window(8, 1, 8'hFF, c);
    check("blink_dark_4of8", 32'(c), 32'd4);
    count_window(8, 0, 8'hF9, c);
    check("blink_other_lit", 32'(c), 32'd8);

    #1 bright = 4'd4;
    repeat (2) @(negedge clk);
    count_window(16, 0, 8'hF9, c);
    check("bright4_on_4of16", 32'(c), 32'd4);
    #1 bright = 4'd0;
    repeat (2) @(negedge clk);
    count_window(16, 0, 8'hFF, c);
    check("bright0_dark", 32'(c), 32'd16);
    #1 bright = 4'hF;

    xfer(16'h1234, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_led", led, 32'hFFFF_FFFF);
    check("midrst_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    c = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (led != 32'hFFFF_FFFF) c++;
    end
    check("midrst_discarded", 32'(c), 32'd0);
    xfer(16'h0007, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    wait_applied();
    check("post_reset_0007", led, 32'hC0C0_C0D8);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
